// File: rtl/control_pipelined_if.sv
// ----------------------------------------------------------------------------
// control_pipelined_if
// Purpose : bundles the ID-stage inputs and the per-stage control outputs of
//           the pipelined MIPS control unit into one interface.
// Modports:
//   master - the pipeline side (IF/ID register, branch unit, datapath muxes).
//            It drives op_id/rs_id/rt_id/flush and consumes the control outputs.
//   slave  - the control unit itself.
// Signals:
//   op_id, rs_id, rt_id  instruction fields currently in ID
//   flush                taken branch/jump resolved in MEM
//   id_extendselect      ID immediate extension select (1 = zero-extend)
//   stall                hold PC and IF/ID
//   ex_*                 ID/EX register contents
//   mem_*                EX/MEM register contents
//   wb_*                 MEM/WB register contents
//   illegal_op           registered one-cycle pulse for an unknown opcode
// ----------------------------------------------------------------------------
interface control_pipelined_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int REG_AW  = 5
);
    logic [OP_W-1:0]    op_id;
    logic [REG_AW-1:0]  rs_id;
    logic [REG_AW-1:0]  rt_id;
    logic               flush;
    logic               id_extendselect;
    logic               stall;
    logic               ex_regdst;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [REG_AW-1:0]  ex_rt;
    logic               ex_maddu_busy;
    logic               mem_branch;
    logic               mem_jump;
    logic               mem_memread;
    logic               mem_memwrite;
    logic               wb_regwrite;
    logic               wb_memtoreg;
    logic               illegal_op;

    modport master (
        output op_id, rs_id, rt_id, flush,
        input  id_extendselect, stall,
        input  ex_regdst, ex_alusrc, ex_aluop, ex_rt, ex_maddu_busy,
        input  mem_branch, mem_jump, mem_memread, mem_memwrite,
        input  wb_regwrite, wb_memtoreg, illegal_op
    );

    modport slave (
        input  op_id, rs_id, rt_id, flush,
        output id_extendselect, stall,
        output ex_regdst, ex_alusrc, ex_aluop, ex_rt, ex_maddu_busy,
        output mem_branch, mem_jump, mem_memread, mem_memwrite,
        output wb_regwrite, wb_memtoreg, illegal_op
    );
endinterface

// File: rtl/control_pipelined.sv
// ----------------------------------------------------------------------------
// control_pipelined
// Purpose : pipelined MIPS control decoder. Decodes the opcode in ID, carries
//           the control bundle through ID/EX, EX/MEM and MEM/WB, detects
//           load-use hazards, holds EX for the multi-cycle maddu and squashes
//           the young stages on a taken branch/jump.
// Ports   :
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    control_pipelined_if.slave (ID inputs, flush, all stage controls)
// ----------------------------------------------------------------------------
module control_pipelined #(
    parameter int OP_W         = 6,
    parameter int ALUOP_W      = 2,
    parameter int REG_AW       = 5,
    parameter int MADDU_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    control_pipelined_if.slave  bus
);

    localparam int CNT_W = (MADDU_CYCLES > 1) ? $clog2(MADDU_CYCLES) : 1;

    localparam logic [OP_W-1:0] OP_R     = OP_W'(0);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MADDU = OP_W'(28);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

    // Control bundle carried from ID into ID/EX
    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               jump;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
    } idex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic jump;
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } exmem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } memwb_ctrl_t;

    idex_ctrl_t  id_ctrl;
    logic        id_ext;
    logic        id_legal;
    logic        id_uses_rt;
    logic        id_is_maddu;

    idex_ctrl_t         idex_q, idex_d;
    logic [REG_AW-1:0]  ex_rt_q, ex_rt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    exmem_ctrl_t        exmem_q, exmem_d;
    memwb_ctrl_t        memwb_q, memwb_d;
    logic               illegal_q, illegal_d;

    logic maddu_busy;
    logic load_use;
    logic stall;

    // ID decode. An unknown opcode decodes to an all-zero bundle so it travels
    // down the pipe as a bubble; id_uses_rt marks opcodes that read rt as a
    // source register (the ones that can suffer a load-use on rt).
    always_comb begin
        id_ctrl     = '0;
        id_ext      = 1'b0;
        id_legal    = 1'b1;
        id_uses_rt  = 1'b0;
        id_is_maddu = 1'b0;
        case (bus.op_id)
            OP_R: begin
                id_ctrl.regdst   = 1'b1;
                id_ctrl.aluop    = ALUOP_W'(2);
                id_ctrl.regwrite = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_ext           = 1'b1;
                id_uses_rt       = 1'b1;
            end
            OP_LW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memread  = 1'b1;
                id_ctrl.regwrite = 1'b1;
            end
            OP_SW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memwrite = 1'b1;
                id_uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.aluop    = ALUOP_W'(1);
                id_ctrl.branch   = 1'b1;
                id_uses_rt       = 1'b1;
            end
            OP_J: begin
                id_ctrl.aluop    = ALUOP_W'(1);
                id_ctrl.branch   = 1'b1;
                id_ctrl.jump     = 1'b1;
            end
            OP_ADDIU: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.regwrite = 1'b1;
            end
            OP_MADDU: begin
                id_ctrl.regdst   = 1'b1;
                id_ctrl.aluop    = ALUOP_W'(2);
                id_ctrl.memtoreg = 1'b1;
                id_ext           = 1'b1;
                id_uses_rt       = 1'b1;
                id_is_maddu      = 1'b1;
            end
            default: id_legal = 1'b0;
        endcase
    end

    // Hazard detection. Register $0 is never a real dependency. Flush wins
    // over everything, so it also masks the stall request.
    always_comb begin
        maddu_busy = (cnt_q != '0);
        load_use   = idex_q.memread && (ex_rt_q != '0) &&
                     ((ex_rt_q == bus.rs_id) ||
                      ((ex_rt_q == bus.rt_id) && id_uses_rt));
        stall      = !bus.flush && (maddu_busy || load_use);
    end

    // Next-state for the stage registers. Priority is flush, then a busy
    // maddu (ID/EX holds, EX/MEM gets a bubble), then load-use (ID/EX gets a
    // bubble). MEM/WB always advances.
    always_comb begin
        idex_d    = idex_ctrl_t'(id_ctrl);
        ex_rt_d   = id_legal ? bus.rt_id : '0;
        cnt_d     = id_is_maddu ? CNT_W'(MADDU_CYCLES - 1) : '0;
        exmem_d   = '{branch:   idex_q.branch,
                      jump:     idex_q.jump,
                      memread:  idex_q.memread,
                      memwrite: idex_q.memwrite,
                      regwrite: idex_q.regwrite,
                      memtoreg: idex_q.memtoreg};
        memwb_d   = '{regwrite: exmem_q.regwrite,
                      memtoreg: exmem_q.memtoreg};
        illegal_d = !id_legal && !bus.flush && !stall;

        if (bus.flush) begin
            idex_d  = '0;
            ex_rt_d = '0;
            cnt_d   = '0;
            exmem_d = '0;
        end else if (maddu_busy) begin
            idex_d  = idex_q;
            ex_rt_d = ex_rt_q;
            cnt_d   = cnt_q - CNT_W'(1);
            exmem_d = '0;
        end else if (load_use) begin
            idex_d  = '0;
            ex_rt_d = '0;
            cnt_d   = '0;
        end
    end

    // Stage registers, cleared asynchronously so every stage reads as a bubble
    // while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q    <= '0;
            ex_rt_q   <= '0;
            cnt_q     <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            ex_rt_q   <= ex_rt_d;
            cnt_q     <= cnt_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.id_extendselect = id_ext;
    assign bus.stall           = stall;
    assign bus.ex_regdst       = idex_q.regdst;
    assign bus.ex_alusrc       = idex_q.alusrc;
    assign bus.ex_aluop        = idex_q.aluop;
    assign bus.ex_rt           = ex_rt_q;
    assign bus.ex_maddu_busy   = maddu_busy;
    assign bus.mem_branch      = exmem_q.branch;
    assign bus.mem_jump        = exmem_q.jump;
    assign bus.mem_memread     = exmem_q.memread;
    assign bus.mem_memwrite    = exmem_q.memwrite;
    assign bus.wb_regwrite     = memwb_q.regwrite;
    assign bus.wb_memtoreg     = memwb_q.memtoreg;
    assign bus.illegal_op      = illegal_q;

endmodule

// File: tb/tb_control_pipelined.sv
// ----------------------------------------------------------------------------
// tb_control_pipelined
// Purpose : directed self-checking bench for control_pipelined (default
//           parameters, MADDU_CYCLES = 4). Inputs change 1 time unit after a
//           rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_control_pipelined;

    localparam logic [5:0] R = 6'd0, J = 6'd2, BEQ = 6'd4, ADDIU = 6'd9;
    localparam logic [5:0] MADDU = 6'd28, LW = 6'd35, SW = 6'd43, BAD = 6'd63;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    control_pipelined_if bus ();

    control_pipelined dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and move to the sampling point just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        bus.op_id = op;
        bus.rs_id = rs;
        bus.rt_id = rt;
        #1;
    endtask

    task automatic do_reset();
        bus.flush = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Power-on reset and a reset pulled in the middle of a maddu
    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        drive(LW, 5'd1, 5'd2);
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL por_stall: got %b want 0", bus.stall); end
        compared++; if (bus.ex_maddu_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL por_busy: got %b want 0", bus.ex_maddu_busy); end
        compared++; if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt} !== 10'd0) begin mismatched++; $display("[TB] FAIL por_ex: got %b want 0", {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt}); end
        compared++; if ({bus.mem_branch, bus.mem_jump, bus.mem_memread, bus.mem_memwrite, bus.wb_regwrite, bus.wb_memtoreg, bus.illegal_op} !== 7'd0) begin mismatched++; $display("[TB] FAIL por_memwb: got %b want 0", {bus.mem_branch, bus.mem_jump, bus.mem_memread, bus.mem_memwrite, bus.wb_regwrite, bus.wb_memtoreg, bus.illegal_op}); end
        step();
        rst_n = 1'b1;
        drive(LW, 5'd1, 5'd8);
        step();
        drive(MADDU, 5'd3, 5'd2);
        step();
        compared++; if (bus.ex_maddu_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_busy_before: got %b want 1", bus.ex_maddu_busy); end
        compared++; if (bus.mem_memread !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_memread_before: got %b want 1", bus.mem_memread); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if ({bus.stall, bus.ex_maddu_busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL mid_stall_busy: got %b want 00", {bus.stall, bus.ex_maddu_busy}); end
        compared++; if ({bus.ex_regdst, bus.ex_aluop, bus.ex_rt, bus.mem_memread, bus.wb_regwrite} !== 10'd0) begin mismatched++; $display("[TB] FAIL mid_regs: got %b want 0", {bus.ex_regdst, bus.ex_aluop, bus.ex_rt, bus.mem_memread, bus.wb_regwrite}); end
        step();
        rst_n = 1'b1;
        drive(ADDIU, 5'd1, 5'd4);
        step();
        compared++; if ({bus.ex_alusrc, bus.ex_rt, bus.ex_maddu_busy} !== {1'b1, 5'd4, 1'b0}) begin mismatched++; $display("[TB] FAIL mid_resume: got %b want %b", {bus.ex_alusrc, bus.ex_rt, bus.ex_maddu_busy}, {1'b1, 5'd4, 1'b0}); end
    endtask

    // Opcode decode flowing through every stage
    task automatic test_decode();
        do_reset();
        drive(SW, 5'd1, 5'd2);
        compared++; if (bus.id_extendselect !== 1'b0) begin mismatched++; $display("[TB] FAIL dec_ext_sw: got %b want 0", bus.id_extendselect); end
        step();
        compared++; if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt} !== {1'b0, 1'b1, 2'b00, 5'd2}) begin mismatched++; $display("[TB] FAIL dec_ex_sw: got %b", {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt}); end
        drive(BEQ, 5'd3, 5'd4);
        step();
        compared++; if ({bus.mem_branch, bus.mem_jump, bus.mem_memread, bus.mem_memwrite} !== 4'b0001) begin mismatched++; $display("[TB] FAIL dec_mem_sw: got %b want 0001", {bus.mem_branch, bus.mem_jump, bus.mem_memread, bus.mem_memwrite}); end
        compared++; if ({bus.ex_alusrc, bus.ex_aluop} !== 3'b001) begin mismatched++; $display("[TB] FAIL dec_ex_beq: got %b want 001", {bus.ex_alusrc, bus.ex_aluop}); end
        drive(J, 5'd0, 5'd0);
        step();
        compared++; if ({bus.mem_branch, bus.mem_jump, bus.mem_memread, bus.mem_memwrite} !== 4'b1000) begin mismatched++; $display("[TB] FAIL dec_mem_beq: got %b want 1000", {bus.mem_branch, bus.mem_jump, bus.mem_memread, bus.mem_memwrite}); end
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b00) begin mismatched++; $display("[TB] FAIL dec_wb_sw: got %b want 00", {bus.wb_regwrite, bus.wb_memtoreg}); end
        drive(R, 5'd5, 5'd6);
        compared++; if (bus.id_extendselect !== 1'b1) begin mismatched++; $display("[TB] FAIL dec_ext_r: got %b want 1", bus.id_extendselect); end
        step();
        compared++; if ({bus.mem_branch, bus.mem_jump} !== 2'b11) begin mismatched++; $display("[TB] FAIL dec_mem_j: got %b want 11", {bus.mem_branch, bus.mem_jump}); end
        compared++; if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt} !== {1'b1, 1'b0, 2'b10, 5'd6}) begin mismatched++; $display("[TB] FAIL dec_ex_r: got %b", {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt}); end
        step();
        step();
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b11) begin mismatched++; $display("[TB] FAIL dec_wb_r: got %b want 11", {bus.wb_regwrite, bus.wb_memtoreg}); end
    endtask

    // lw $8 followed by add $9,$8,$1: one stall, one bubble, WB gap of one
    task automatic test_load_use();
        do_reset();
        drive(LW, 5'd1, 5'd8);
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_pre_stall: got %b want 0", bus.stall); end
        step();
        drive(R, 5'd8, 5'd1);
        compared++; if (bus.stall !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_stall: got %b want 1", bus.stall); end
        step();
        compared++; if ({bus.ex_regdst, bus.ex_aluop, bus.ex_rt} !== 8'd0) begin mismatched++; $display("[TB] FAIL lu_bubble: got %b want 0", {bus.ex_regdst, bus.ex_aluop, bus.ex_rt}); end
        compared++; if (bus.mem_memread !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_lw_mem: got %b want 1", bus.mem_memread); end
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_stall_release: got %b want 0", bus.stall); end
        step();
        compared++; if ({bus.ex_regdst, bus.ex_rt} !== {1'b1, 5'd1}) begin mismatched++; $display("[TB] FAIL lu_add_ex: got %b", {bus.ex_regdst, bus.ex_rt}); end
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b10) begin mismatched++; $display("[TB] FAIL lu_lw_wb: got %b want 10", {bus.wb_regwrite, bus.wb_memtoreg}); end
        drive(ADDIU, 5'd2, 5'd3);
        step();
        compared++; if (bus.wb_regwrite !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_bubble_wb: got %b want 0", bus.wb_regwrite); end
        step();
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b11) begin mismatched++; $display("[TB] FAIL lu_add_wb: got %b want 11", {bus.wb_regwrite, bus.wb_memtoreg}); end
    endtask

    // rt-only matches stall only for ops that read rt; $0 never stalls
    task automatic test_load_use_rt();
        do_reset();
        drive(LW, 5'd1, 5'd5);
        step();
        drive(SW, 5'd2, 5'd5);
        compared++; if (bus.stall !== 1'b1) begin mismatched++; $display("[TB] FAIL lurt_sw: got %b want 1", bus.stall); end
        drive(ADDIU, 5'd2, 5'd5);
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL lurt_addiu: got %b want 0", bus.stall); end
        drive(MADDU, 5'd2, 5'd5);
        compared++; if (bus.stall !== 1'b1) begin mismatched++; $display("[TB] FAIL lurt_maddu: got %b want 1", bus.stall); end
        do_reset();
        drive(LW, 5'd1, 5'd0);
        step();
        drive(R, 5'd0, 5'd1);
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_rs: got %b want 0", bus.stall); end
        drive(R, 5'd0, 5'd0);
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_rsrt: got %b want 0", bus.stall); end
        step();
        compared++; if ({bus.ex_regdst, bus.mem_memread} !== 2'b11) begin mismatched++; $display("[TB] FAIL zero_advance: got %b want 11", {bus.ex_regdst, bus.mem_memread}); end
    endtask

    // maddu followed by addiu with MADDU_CYCLES = 4
    task automatic test_maddu();
        logic exp_stall [5];
        exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        drive(MADDU, 5'd1, 5'd2);
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL md_pre_stall: got %b want 0", bus.stall); end
        step();
        compared++; if ({bus.ex_regdst, bus.ex_aluop, bus.ex_rt} !== {1'b1, 2'b10, 5'd2}) begin mismatched++; $display("[TB] FAIL md_ex: got %b", {bus.ex_regdst, bus.ex_aluop, bus.ex_rt}); end
        drive(ADDIU, 5'd3, 5'd4);
        for (int k = 0; k < 5; k++) begin
            compared++; if (bus.stall !== exp_stall[k]) begin mismatched++; $display("[TB] FAIL md_stall[%0d]: got %b want %b", k, bus.stall, exp_stall[k]); end
            compared++; if (bus.ex_maddu_busy !== exp_stall[k]) begin mismatched++; $display("[TB] FAIL md_busy[%0d]: got %b want %b", k, bus.ex_maddu_busy, exp_stall[k]); end
            compared++; if (bus.wb_memtoreg !== 1'b0) begin mismatched++; $display("[TB] FAIL md_wb_bubble[%0d]: got %b want 0", k, bus.wb_memtoreg); end
            if (k == 3) begin
                compared++; if (bus.ex_rt !== 5'd2) begin mismatched++; $display("[TB] FAIL md_hold: got %0d want 2", bus.ex_rt); end
            end
            step();
        end
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b01) begin mismatched++; $display("[TB] FAIL md_wb: got %b want 01", {bus.wb_regwrite, bus.wb_memtoreg}); end
        compared++; if ({bus.ex_alusrc, bus.ex_rt} !== {1'b1, 5'd4}) begin mismatched++; $display("[TB] FAIL md_addiu_ex_late: got %b", {bus.ex_alusrc, bus.ex_rt}); end
    endtask

    // Second maddu waits in ID until the first leaves
    task automatic test_back_to_back();
        do_reset();
        drive(MADDU, 5'd1, 5'd2);
        step();
        drive(MADDU, 5'd3, 5'd5);
        step();
        step();
        compared++; if ({bus.stall, bus.ex_rt} !== {1'b1, 5'd2}) begin mismatched++; $display("[TB] FAIL b2b_wait: got %b", {bus.stall, bus.ex_rt}); end
        step();
        compared++; if ({bus.stall, bus.ex_maddu_busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL b2b_release: got %b want 00", {bus.stall, bus.ex_maddu_busy}); end
        step();
        compared++; if ({bus.ex_maddu_busy, bus.ex_rt, bus.stall} !== {1'b1, 5'd5, 1'b1}) begin mismatched++; $display("[TB] FAIL b2b_second: got %b", {bus.ex_maddu_busy, bus.ex_rt, bus.stall}); end
    endtask

    // Flush beats a busy maddu and a pending load-use
    task automatic test_flush();
        do_reset();
        drive(LW, 5'd1, 5'd7);
        step();
        drive(MADDU, 5'd2, 5'd3);
        step();
        drive(R, 5'd7, 5'd3);
        bus.flush = 1'b1;
        #1;
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_md_stall: got %b want 0", bus.stall); end
        step();
        bus.flush = 1'b0;
        compared++; if ({bus.ex_regdst, bus.ex_aluop, bus.ex_rt, bus.ex_maddu_busy} !== 9'd0) begin mismatched++; $display("[TB] FAIL fl_md_ex: got %b want 0", {bus.ex_regdst, bus.ex_aluop, bus.ex_rt, bus.ex_maddu_busy}); end
        compared++; if (bus.mem_memread !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_md_mem: got %b want 0", bus.mem_memread); end
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b10) begin mismatched++; $display("[TB] FAIL fl_md_wb: got %b want 10", {bus.wb_regwrite, bus.wb_memtoreg}); end
        do_reset();
        drive(LW, 5'd1, 5'd8);
        step();
        drive(R, 5'd8, 5'd1);
        bus.flush = 1'b1;
        #1;
        compared++; if (bus.stall !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_lu_stall: got %b want 0", bus.stall); end
        step();
        bus.flush = 1'b0;
        compared++; if ({bus.ex_regdst, bus.mem_memread} !== 2'b00) begin mismatched++; $display("[TB] FAIL fl_lu_regs: got %b want 00", {bus.ex_regdst, bus.mem_memread}); end
    endtask

    // Unknown opcode: bubble plus a one-cycle illegal_op pulse unless
    // flushed or stalled
    task automatic test_illegal();
        do_reset();
        drive(R, 5'd1, 5'd2);
        step();
        drive(BAD, 5'd3, 5'd4);
        compared++; if (bus.id_extendselect !== 1'b0) begin mismatched++; $display("[TB] FAIL il_ext: got %b want 0", bus.id_extendselect); end
        step();
        compared++; if (bus.illegal_op !== 1'b1) begin mismatched++; $display("[TB] FAIL il_pulse: got %b want 1", bus.illegal_op); end
        compared++; if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt} !== 10'd0) begin mismatched++; $display("[TB] FAIL il_ex: got %b want 0", {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_rt}); end
        drive(ADDIU, 5'd1, 5'd2);
        step();
        compared++; if (bus.illegal_op !== 1'b0) begin mismatched++; $display("[TB] FAIL il_pulse_end: got %b want 0", bus.illegal_op); end
        step();
        compared++; if ({bus.wb_regwrite, bus.wb_memtoreg} !== 2'b00) begin mismatched++; $display("[TB] FAIL il_wb: got %b want 00", {bus.wb_regwrite, bus.wb_memtoreg}); end
        drive(BAD, 5'd0, 5'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        compared++; if (bus.illegal_op !== 1'b0) begin mismatched++; $display("[TB] FAIL il_flush: got %b want 0", bus.illegal_op); end
        do_reset();
        drive(LW, 5'd1, 5'd8);
        step();
        drive(BAD, 5'd8, 5'd0);
        step();
        compared++; if (bus.illegal_op !== 1'b0) begin mismatched++; $display("[TB] FAIL il_stalled: got %b want 0", bus.illegal_op); end
        step();
        compared++; if (bus.illegal_op !== 1'b1) begin mismatched++; $display("[TB] FAIL il_after_stall: got %b want 1", bus.illegal_op); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_decode();
        test_load_use();
        test_load_use_rt();
        test_maddu();
        test_back_to_back();
        test_flush();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
